mult_arbiter: RTL and testbench

- Shares one pipelined N-bit multiplier among NREQ requesters.
- Each requester has a valid/ready request channel. A round-robin arbiter grants one request per cycle and drives the multiplier operand/enable pins.
- Each issued operation carries a requester-ID tag through a shadow pipeline that matches the multiplier latency.
- Products are buffered in a credit-protected response FIFO that drives a single tagged response channel with backpressure.

---
 rtl/mult_arb_pkg.sv | 29 ++
 rtl/mult_arbiter_if.sv | 36 +++
 rtl/mult_rsp_fifo.sv | 61 ++++++
 rtl/mult_arbiter.sv | 115 +++++++++++
 tb/tb_mult_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
package mult_arb_pkg;

    // Index width for n items, never narrower than one bit.
    function automatic int idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int ARB_N     = 8;
    localparam int ARB_NREQ  = 4;
    localparam int ARB_LAT   = 2;
    localparam int ARB_DEPTH = 4;

    localparam int IDW = idw(ARB_NREQ);
    localparam int PW  = 2 * ARB_N;

    // One stage of the requester-ID shadow pipeline.
    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    // One buffered response: product plus the requester that asked for it.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  data;
    } rsp_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Request, multiplier-pin and response signals of the shared multiplier.
interface mult_arbiter_if #(
    parameter int N    = 8,
    parameter int NREQ = 4
) ();
    import mult_arb_pkg::*;

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*N-1:0]        req_a;
    logic [NREQ*N-1:0]        req_b;
    logic [N-1:0]             Data_in_A;
    logic [N-1:0]             Data_in_B;
    logic                     EA;
    logic                     EB;
    logic [2*N-1:0]           P_out;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [2*N-1:0]           rsp_data;
    logic [idw(NREQ)-1:0]     rsp_id;

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, P_out, rsp_ready,
        output req_ready, Data_in_A, Data_in_B, EA, EB,
               rsp_valid, rsp_data, rsp_id
    );

    // Requesters, multiplier and response consumer side.
    modport master (
        output req_valid, req_a, req_b, P_out, rsp_ready,
        input  req_ready, Data_in_A, Data_in_B, EA, EB,
               rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/mult_rsp_fifo.sv
// First-word-fall-through response FIFO with an occupancy count.
module mult_rsp_fifo
    import mult_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = idw(DEPTH),
    localparam int CW   = idw(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same edge, so full+push+pop is legal.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage, pointers and count; pointers wrap explicitly so DEPTH need not be 2^k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The credit scheme upstream must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters,
// with tagged, credit-protected, in-order responses.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int NREQ  = ARB_NREQ,
    parameter int LAT   = ARB_LAT,
    parameter int DEPTH = ARB_DEPTH
) (
    input  logic          clk,
    input  logic          Reset_n,
    mult_arbiter_if.slave bus
);

    localparam int CW = idw(DEPTH + 1);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] win;
    logic           found;
    logic           credit;
    logic           issue;
    int             idx;
    int             occ;
    tag_t           tag_q [LAT];
    logic [CW-1:0]  fifo_cnt;
    logic           fifo_empty;
    rsp_t           push_rsp;
    rsp_t           head_rsp;

    // Occupancy from registered state only: buffered results plus in-flight tags.
    always_comb begin
        occ = int'(fifo_cnt);
        for (int s = 0; s < LAT; s++) occ = occ + int'(tag_q[s].vld);
    end

    assign credit = (occ < DEPTH);
    // Gating with reset keeps every output quiet while reset is held.
    assign issue  = found && credit && Reset_n;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Grant and multiplier operand drive; everything idles to zero without an issue.
    always_comb begin
        bus.req_ready = '0;
        bus.EA        = 1'b0;
        bus.EB        = 1'b0;
        bus.Data_in_A = '0;
        bus.Data_in_B = '0;
        if (issue) begin
            bus.req_ready[win] = 1'b1;
            bus.EA             = 1'b1;
            bus.EB             = 1'b1;
            bus.Data_in_A      = bus.req_a[int'(win)*N +: N];
            bus.Data_in_B      = bus.req_b[int'(win)*N +: N];
        end
    end

    // Pointer moves just past the winner on every issue.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)   ptr_q <= '0;
        else if (issue) ptr_q <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    // Shadow pipeline carrying the requester ID alongside the multiplier.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= '{vld: issue, id: win};
            for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // The final tag stage lines up with the product on P_out.
    assign push_rsp = '{id: tag_q[LAT-1].id, data: bus.P_out};

    mult_rsp_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(rsp_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (Reset_n),
        .push  (tag_q[LAT-1].vld),
        .wdata (push_rsp),
        .pop   (bus.rsp_valid && bus.rsp_ready),
        .rdata (head_rsp),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_data  = head_rsp.data;
    assign bus.rsp_id    = head_rsp.id;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!Reset_n)
        $onehot0(bus.req_ready));
    a_ea_eq_eb: assert property (@(posedge clk) disable iff (!Reset_n)
        bus.EA == bus.EB);
    a_rsp_id_range: assert property (@(posedge clk) disable iff (!Reset_n)
        int'(bus.rsp_id) < NREQ);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a transaction-level reference model.
module tb_mult_arbiter;

    localparam int N     = 8;
    localparam int NREQ  = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic Reset_n;

    mult_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    mult_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: product appears LAT cycles after the enable cycle.
    logic [2*N-1:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= (2*N)'(bus.Data_in_A) * (2*N)'(bus.Data_in_B);
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign bus.P_out = mp[LAT-1];

    typedef struct {
        int id;
        int data;
        int cyc;
    } item_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    m_ptr = 0;     // model round-robin pointer
    int    m_occ = 0;     // issued minus popped
    item_t q[$];          // expected responses, rdy cycle in .cyc
    int    og[$];         // observed grants
    item_t orsp[$];       // observed accepted responses
    int    icyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: check this cycle's outputs against the model, then advance.
    task automatic step();
        int            win;
        int            idx;
        logic          found;
        logic          exp_rv;
        logic [NREQ-1:0] exp_rdy;
        logic [N-1:0]  ea;
        logic [N-1:0]  eb;
        @(negedge clk);
        found = 1'b0;
        win   = 0;
        if (m_occ < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && bus.req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        exp_rdy = '0;
        ea = '0;
        eb = '0;
        if (found) begin
            exp_rdy[win] = 1'b1;
            ea = bus.req_a[win*N +: N];
            eb = bus.req_b[win*N +: N];
        end
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("EA", 32'(bus.EA), 32'(found));
        chk("EB", 32'(bus.EB), 32'(found));
        chk("Data_in_A", 32'(bus.Data_in_A), 32'(ea));
        chk("Data_in_B", 32'(bus.Data_in_B), 32'(eb));
        exp_rv = (q.size() > 0) && (q[0].cyc <= cyc);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
            chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
        end
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) og.push_back(i);
        if (bus.rsp_valid && bus.rsp_ready)
            orsp.push_back('{int'(bus.rsp_id), int'(bus.rsp_data), cyc});
        if (exp_rv && bus.rsp_ready) begin
            void'(q.pop_front());
            m_occ--;
        end
        if (found) begin
            q.push_back('{win, int'(ea) * int'(eb), cyc + LAT + 1});
            m_occ++;
            m_ptr = (win + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_op(input int r, input int a, input int b);
        bus.req_a[r*N +: N] = N'(a);
        bus.req_b[r*N +: N] = N'(b);
    endtask

    initial begin
        Reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_EA", 32'(bus.EA), 0);
        chk("rst_EB", 32'(bus.EB), 0);
        chk("rst_Data_in_A", 32'(bus.Data_in_A), 0);
        chk("rst_Data_in_B", 32'(bus.Data_in_B), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        Reset_n = 1'b1;

        // All four requesters: RR order 0..3, products 10..40.
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10);
        og.delete(); orsp.delete();
        bus.req_valid = '1;
        run(4);
        bus.req_valid = '0;
        run(6);
        chk("all4_grants", og.size(), 4);
        chk("all4_rsps", orsp.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("all4_grant_order", og[i], i);
            chk("all4_rsp_data", orsp[i].data, 10 * (i + 1));
            chk("all4_rsp_id", orsp[i].id, i);
        end
        og.delete();
        bus.req_valid = '1;
        run(1);
        bus.req_valid = '0;
        chk("ptr_wrap_grant", og[0], 0);
        run(6);

        // Single request from requester 2: 3*5 with 3-cycle latency.
        orsp.delete();
        set_op(2, 3, 5);
        bus.req_valid = 4'b0100;
        icyc = cyc;
        run(1);
        bus.req_valid = '0;
        run(6);
        chk("single_cnt", orsp.size(), 1);
        chk("single_data", orsp[0].data, 15);
        chk("single_id", orsp[0].id, 2);
        chk("single_latency", orsp[0].cyc - icyc, 3);

        // Backpressure: exactly DEPTH accepts, resume one cycle after rsp_ready.
        og.delete(); orsp.delete();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
        bus.req_valid = '1;
        run(8);
        chk("bp_accepts", og.size(), DEPTH);
        bus.rsp_ready = 1'b1;
        run(1);
        chk("bp_no_same_cycle_credit", og.size(), DEPTH);
        run(1);
        chk("bp_resume", og.size(), DEPTH + 1);
        run(10);
        bus.req_valid = '0;
        run(8);
        chk("bp_no_loss", orsp.size(), og.size());

        // Operand extremes at full product width.
        orsp.delete();
        bus.req_valid = 4'b0010;
        set_op(1, 255, 255); run(1);
        set_op(1, 0, 200);   run(1);
        set_op(1, 1, 255);   run(1);
        bus.req_valid = '0;
        run(6);
        chk("ext_cnt", orsp.size(), 3);
        chk("ext_255x255", orsp[0].data, 65025);
        chk("ext_0x200", orsp[1].data, 0);
        chk("ext_1x255", orsp[2].data, 255);

        // Fairness between requesters 0 and 3.
        og.delete();
        set_op(0, 2, 2);
        set_op(3, 4, 4);
        bus.req_valid = 4'b1001;
        run(8);
        bus.req_valid = '0;
        chk("fair_cnt", og.size(), 8);
        for (int i = 1; i < 8; i++) begin
            chk("fair_alternate", 32'(og[i] != og[i-1]), 1);
            chk("fair_members", 32'(og[i] == 0 || og[i] == 3), 1);
        end
        run(6);

        // Reset with two in flight and one buffered.
        bus.rsp_ready = 1'b0;
        set_op(1, 9, 9);
        bus.req_valid = 4'b0010;
        run(3);
        bus.req_valid = 4'b0100;
        Reset_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("midrst_req_ready", 32'(bus.req_ready), 0);
        chk("midrst_EA", 32'(bus.EA), 0);
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
        bus.req_valid = '0;
        cyc++;
        q.delete();
        m_occ = 0;
        m_ptr = 0;
        bus.rsp_ready = 1'b1;
        orsp.delete();
        run(6);
        chk("midrst_no_stale", orsp.size(), 0);
        set_op(3, 7, 9);
        bus.req_valid = 4'b1000;
        run(1);
        bus.req_valid = '0;
        run(6);
        chk("midrst_next_cnt", orsp.size(), 1);
        chk("midrst_next_data", orsp[0].data, 63);
        chk("midrst_next_id", orsp[0].id, 3);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = NREQ'($urandom);
            bus.req_a     = (NREQ*N)'($urandom);
            bus.req_b     = (NREQ*N)'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
